// File: rtl/girl_sprite_anim.sv
// rtl/girl_sprite_anim.sv - Watergirl walk-animation sequencer and sprite ROM address generator
module girl_sprite_anim #(
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 40,
  parameter int FRAME_DIV = 6
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  girl_x,
  input  logic [9:0]  girl_y,
  input  logic        move_left,
  input  logic        move_right,
  output logic [11:0] rom_address,
  output logic        sprite_on,
  output logic        facing_right,
  output logic [2:0]  anim_frame
);

  localparam int AW       = 12;
  localparam int CW       = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DW       = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int FRAME_SZ = SPR_W * SPR_H;

  typedef enum logic [0:0] {S_IDLE, S_WALK} state_t;

  state_t         r_state;
  logic           r_vsync;
  logic [9:0]     r_px;
  logic [9:0]     r_py;
  logic           r_facing;
  logic [1:0]     r_walk_idx;
  logic [3:0]     r_div_cnt;
  logic [2:0]     r_anim_frame;

  logic           r_s1_on;
  logic [DW-1:0]  r_s1_dy;
  logic [CW-1:0]  r_s1_col;
  logic           r_s2_on;
  logic [AW-1:0]  r_s2_addr;

  logic           w_tick;
  logic           w_walk;
  logic [1:0]     w_next_idx;
  logic [10:0]    w_x11;
  logic [10:0]    w_y11;
  logic [10:0]    w_px11;
  logic [10:0]    w_py11;
  logic           w_in_box;
  logic [CW-1:0]  w_dx;
  logic [DW-1:0]  w_dy;
  logic [CW-1:0]  w_col;
  logic [AW-1:0]  w_addr;

  assign w_tick     = vsync & ~r_vsync;
  assign w_walk     = move_left ^ move_right;
  assign w_next_idx = r_walk_idx + 2'd1;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync <= 1'b1;
      r_px    <= '0;
      r_py    <= '0;
    end else begin
      r_vsync <= vsync;
      if (w_tick) begin
        r_px <= girl_x;
        r_py <= girl_y;
      end
    end
  end

  // Movement is sampled only on the frame tick so the pose never changes mid-frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_facing     <= 1'b0;
      r_walk_idx   <= '0;
      r_div_cnt    <= '0;
      r_anim_frame <= '0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_walk) begin
            r_state      <= S_WALK;
            r_facing     <= move_right;
            r_walk_idx   <= '0;
            r_div_cnt    <= '0;
            r_anim_frame <= 3'd1;
          end
        end
        S_WALK: begin
          if (!w_walk) begin
            r_state      <= S_IDLE;
            r_walk_idx   <= '0;
            r_div_cnt    <= '0;
            r_anim_frame <= 3'd0;
          end else if (move_right != r_facing) begin
            r_facing     <= move_right;
            r_walk_idx   <= '0;
            r_div_cnt    <= '0;
            r_anim_frame <= 3'd1;
          end else if (r_div_cnt == 4'(FRAME_DIV - 1)) begin
            r_div_cnt    <= '0;
            r_walk_idx   <= w_next_idx;
            r_anim_frame <= {1'b0, w_next_idx} + 3'd1;
          end else begin
            r_div_cnt    <= r_div_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // 11-bit compare keeps px+SPR_W from wrapping near the right edge.
  assign w_x11    = {1'b0, DrawX};
  assign w_y11    = {1'b0, DrawY};
  assign w_px11   = {1'b0, r_px};
  assign w_py11   = {1'b0, r_py};
  assign w_in_box = (w_x11 >= w_px11) && (w_x11 < w_px11 + 11'(SPR_W)) &&
                    (w_y11 >= w_py11) && (w_y11 < w_py11 + 11'(SPR_H));
  assign w_dx     = CW'(DrawX - r_px);
  assign w_dy     = DW'(DrawY - r_py);
  assign w_col    = r_facing ? (CW'(SPR_W - 1) - w_dx) : w_dx;

  assign w_addr = AW'(r_anim_frame) * AW'(FRAME_SZ) +
                  AW'(r_s1_dy) * AW'(SPR_W) + AW'(r_s1_col);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_on   <= 1'b0;
      r_s1_dy   <= '0;
      r_s1_col  <= '0;
      r_s2_on   <= 1'b0;
      r_s2_addr <= '0;
    end else begin
      r_s1_on   <= w_in_box;
      r_s1_dy   <= w_dy;
      r_s1_col  <= w_col;
      r_s2_on   <= r_s1_on;
      r_s2_addr <= r_s1_on ? w_addr : '0;
    end
  end

  assign rom_address  = r_s2_addr;
  assign sprite_on    = r_s2_on;
  assign facing_right = r_facing;
  assign anim_frame   = r_anim_frame;

endmodule

// File: tb/tb_girl_sprite_anim.sv
// tb/tb_girl_sprite_anim.sv - directed bench for girl_sprite_anim
module tb_girl_sprite_anim;

  logic        vga_clk;
  logic        reset_n;
  logic        vsync;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  girl_x;
  logic [9:0]  girl_y;
  logic        move_left;
  logic        move_right;
  logic [11:0] rom_address;
  logic        sprite_on;
  logic        facing_right;
  logic [2:0]  anim_frame;

  int n_tests = 0;
  int n_fail  = 0;

  girl_sprite_anim #(.SPR_W(20), .SPR_H(40), .FRAME_DIV(6)) dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .girl_x       (girl_x),
    .girl_y       (girl_y),
    .move_left    (move_left),
    .move_right   (move_right),
    .rom_address  (rom_address),
    .sprite_on    (sprite_on),
    .facing_right (facing_right),
    .anim_frame   (anim_frame)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame_tick();
    @(negedge vga_clk); vsync = 1'b0;
    @(negedge vga_clk); vsync = 1'b1;
    @(negedge vga_clk);
  endtask

  task automatic scan(input int x, input int y);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge vga_clk);
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic scan_check(input string tag, input int x, input int y,
                            input int exp_on, input int exp_addr);
    scan(x, y);
    check({tag, "_on"}, int'(sprite_on), exp_on);
    check({tag, "_addr"}, int'(rom_address), exp_addr);
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b1; DrawX = '0; DrawY = '0;
    girl_x = 10'd100; girl_y = 10'd200; move_left = 1'b0; move_right = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("rst_addr",   int'(rom_address), 0);
    check("rst_on",     int'(sprite_on), 0);
    check("rst_facing", int'(facing_right), 0);
    check("rst_anim",   int'(anim_frame), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge vga_clk);
    // px must still be 0: no tick at release
    scan_check("no_tick_release", 0, 0, 1, 0);
    scan_check("no_tick_100", 100, 200, 0, 0);

    frame_tick();
    check("idle_anim", int'(anim_frame), 0);
    scan_check("idle_tl",    100, 200, 1, 0);
    scan_check("idle_br",    119, 239, 1, 799);
    scan_check("idle_xend",  120, 239, 0, 0);
    scan_check("idle_xpre",   99, 200, 0, 0);
    scan_check("idle_yend",  100, 240, 0, 0);

    move_left = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      frame_tick();
      if (t == 1)  check("walk_t1",  int'(anim_frame), 1);
      if (t == 6)  check("walk_t6",  int'(anim_frame), 1);
      if (t == 7)  check("walk_t7",  int'(anim_frame), 2);
      if (t == 13) check("walk_t13", int'(anim_frame), 3);
      if (t == 19) check("walk_t19", int'(anim_frame), 4);
      if (t == 25) check("walk_t25", int'(anim_frame), 1);
    end
    check("walk_left_facing", int'(facing_right), 0);

    move_left = 1'b0; move_right = 1'b1;
    frame_tick();
    check("rev_r_anim",   int'(anim_frame), 1);
    check("rev_r_facing", int'(facing_right), 1);
    repeat (6) frame_tick();
    check("right_f2_anim", int'(anim_frame), 2);
    scan_check("right_f2_col19", 100, 200, 1, 1619);
    scan_check("right_f2_col0",  119, 200, 1, 1600);

    repeat (6) frame_tick();
    check("right_f3_anim", int'(anim_frame), 3);
    move_left = 1'b1; move_right = 1'b0;
    frame_tick();
    check("rev_l_anim",   int'(anim_frame), 1);
    check("rev_l_facing", int'(facing_right), 0);
    move_left = 1'b0; move_right = 1'b1;
    frame_tick();
    check("rev_r2_facing", int'(facing_right), 1);
    move_left = 1'b1;
    frame_tick();
    check("both_anim",   int'(anim_frame), 0);
    check("both_facing", int'(facing_right), 1);
    move_left = 1'b0; move_right = 1'b0;

    girl_x = 10'd300;
    scan_check("midframe_old", 100, 200, 1, 19);
    scan_check("midframe_new", 300, 200, 0, 0);
    frame_tick();
    scan_check("newframe_new", 300, 200, 1, 19);
    scan_check("newframe_old", 100, 200, 0, 0);
    girl_x = 10'd630;
    frame_tick();
    scan_check("edge_639", 639, 200, 1, 10);
    scan_check("edge_649", 649, 200, 1, 0);
    scan_check("edge_650", 650, 200, 0, 0);
    scan_check("edge_5",     5, 200, 0, 0);

    girl_x = 10'd100;
    move_left = 1'b1;
    repeat (13) frame_tick();
    check("pre_rst_anim",   int'(anim_frame), 3);
    check("pre_rst_facing", int'(facing_right), 0);
    scan_check("pre_rst", 100, 200, 1, 2400);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_anim", int'(anim_frame), 0);
    check("async_rst_on",   int'(sprite_on), 0);
    check("async_rst_addr", int'(rom_address), 0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge vga_clk);
    check("post_rst_anim", int'(anim_frame), 0);
    scan_check("post_rst_px0", 0, 0, 1, 0);
    frame_tick();
    check("restart_anim", int'(anim_frame), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/girl_sprite_anim.md
# girl_sprite_anim

Walk-animation sequencer and sprite address generator for the Watergirl character. It sits directly upstream of the girl sprite ROM/palette stage and drives that stage's ROM address from the VGA scan position, the character's screen position and its movement state. Movement inputs and position are latched once per video frame to keep updates tear-free. The block also flags which scan pixels fall inside the 20x40 sprite box, so the compositor can gate the palette output.

## Interface
Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- FRAME_DIV, 6, video frames per walk-animation step (1..15)

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  VGA vertical sync, active-low; rising edge = frame tick
- DrawX  in  10  current scan column
- DrawY  in  10  current scan row
- girl_x  in  10  sprite top-left column (requested)
- girl_y  in  10  sprite top-left row (requested)
- move_left  in  1  player moving left
- move_right  in  1  player moving right
- rom_address  out  12  sprite ROM address, frame base + pixel offset
- sprite_on  out  1  current (delayed) pixel lies inside the sprite box
- facing_right  out  1  0 = facing left, 1 = facing right
- anim_frame  out  3  ROM frame index in use: 0 = idle, 1..4 = walk

## Operation
- Frame tick: a one-cycle pulse on the vsync 0->1 transition, from a registered copy of vsync. The registered copy resets to 1, so no tick fires at reset release.
- On each frame tick the block latches girl_x/girl_y into shadow registers px/py. All address math uses px/py only.
- Direction decode on frame tick: exactly one of move_left or move_right set = walking in that direction. Neither set, or both set = idle.
- FSM states: IDLE, WALK.
- IDLE -> WALK on a frame tick with a walking direction. Set facing, walk_idx=0, div_cnt=0.
- WALK -> IDLE on a frame tick with no walking direction. facing_right is held; walk_idx is cleared.
- WALK, same direction on the tick: div_cnt increments. At FRAME_DIV-1 it wraps to 0 and walk_idx advances 0->1->2->3->0.
- WALK, opposite direction on the tick: facing flips, walk_idx=0, div_cnt=0.
- anim_frame = 0 in IDLE, or walk_idx+1 in WALK.
- Sprite art is stored left-facing. When facing_right=1 the column is mirrored: col = SPR_W-1-dx; otherwise col = dx.
- In-box test uses 11-bit arithmetic so px+SPR_W never wraps: DrawX >= px and DrawX < px+SPR_W, and DrawY >= py and DrawY < py+SPR_H. dx = DrawX-px, dy = DrawY-py.
- Address = anim_frame*SPR_W*SPR_H + dy*SPR_W + col. The maximum is 4*800+799 = 3999, which fits in 12 bits.
- Outside the box: sprite_on=0 and rom_address=0.

## Timing
- Reset (async assert, sync release) values: rom_address=0, sprite_on=0, facing_right=0, anim_frame=0, FSM=IDLE, walk_idx=0, div_cnt=0, px=py=0, registered vsync=1.
- Pipeline latency is 2 vga_clk cycles from DrawX/DrawY to rom_address/sprite_on. One new result is produced every cycle.
- Stage 1 registers the in-box flag, dy, and col (mirroring applied).
- Stage 2 registers the final address and sprite_on.
- facing_right and anim_frame change only in the cycle after a frame tick. They are registered and stable for the whole visible frame.
- px/py update in the cycle after the tick. Changes to girl_x/girl_y between ticks have no effect.
- Reset mid-frame clears everything immediately. Animation restarts from IDLE at the next tick that carries a direction.

## Test plan
- Reset, then px=100, py=200 latched on a tick, idle. Scan DrawX=100, DrawY=200 -> 2 cycles later sprite_on=1, rom_address=0. DrawX=119, DrawY=239 -> rom_address=799. DrawX=120 -> sprite_on=0, rom_address=0.
- move_left held with FRAME_DIV=6 -> anim_frame: 1 after tick 1, 2 after tick 7, 3 after tick 13, 4 after tick 19, 1 after tick 25. facing_right stays 0.
- move_right, walk frame 2, px=100, DrawX=100, DrawY=py -> col=19, rom_address=2*800+19=1619. facing_right=1.
- Direction reversal mid-walk (walk_idx=2 -> move_left) -> next tick gives anim_frame=1 and facing_right=0. Both buttons held -> anim_frame=0 and facing unchanged.
- girl_x changed from 100 to 300 mid-frame -> sprite_on still keyed to 100 until the next vsync rising edge, then keyed to 300. px=630 -> DrawX=639 is in-box with no wrap, and DrawX=5 is not in-box.
- reset_n pulsed low mid-WALK (anim_frame=3) -> outputs go to 0 asynchronously. No frame tick fires at release while vsync is high.
